// File: rtl/branch_pkg.sv
// Shared types for the branch unit: condition bit indices,
// opcode enum and the ret > call > branch priority encoder.
package branch_pkg;

    localparam int FLAG_W = 4;

    localparam int COND_ALWAYS  = 0;
    localparam int COND_LESS    = 1;
    localparam int COND_EQUAL   = 2;
    localparam int COND_GREATER = 3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_BR,
        OP_CALL,
        OP_RET
    } br_op_t;

    function automatic br_op_t op_decode(
        input logic br,
        input logic call,
        input logic ret
    );
        br_op_t op;
        op = OP_NONE;
        priority case (1'b1)
            ret:     op = OP_RET;
            call:    op = OP_CALL;
            br:      op = OP_BR;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push while full overwrites the oldest.
// Ports: push/pop/din in, dout (top entry), empty/full, sticky overflow/underflow.
module return_stack
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("return_stack: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [W-1:0]  mem_q [DEPTH];

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign dout      = mem_q[top_q];

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            top_d = top_q + PW'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage has no reset; a push in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[top_d] <= din;
    end

endmodule

// File: rtl/branch_unit_rs.sv
// Branch controller: flag register, condition logic, target mux, return stack.
// Ports: ALU equal/less, flag write, opcode strobes, immediate, pc_next in;
// address/branch redirect, flag_q and stack status out.
module branch_unit_rs
    import branch_pkg::*;
#(
    parameter int IMM_W       = 6,
    parameter int SHIFT       = 3,
    parameter int ADDR_W      = 9,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              equal,
    input  logic              less,
    input  logic              w_flag,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic              branch_instr,
    input  logic              call_instr,
    input  logic              ret_instr,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] address,
    output logic              branch,
    output logic [FLAG_W-1:0] flag_q,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow
);

    if (ADDR_W < IMM_W + SHIFT) begin : g_width_chk
        $error("branch_unit_rs: ADDR_W must be >= IMM_W + SHIFT");
    end

    logic [FLAG_W-1:0] flag_d;
    br_op_t            op;
    logic              taken;
    logic [ADDR_W-1:0] imm_sh;
    logic [ADDR_W-1:0] ras_top;

    assign flag_d = w_flag ? flag_in : flag_q;

    always_ff @(posedge clk) begin
        if (reset) flag_q <= '0;
        else       flag_q <= flag_d;
    end

    assign op = op_decode(branch_instr, call_instr, ret_instr);

    // Decision uses the registered flags, never flag_in.
    assign taken = flag_q[COND_ALWAYS]
                 | (flag_q[COND_LESS]    & less)
                 | (flag_q[COND_EQUAL]   & equal)
                 | (flag_q[COND_GREATER] & ~less & ~equal);

    assign imm_sh = ADDR_W'(immediate) << SHIFT;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .din       (pc_next),
        .dout      (ras_top),
        .empty     (stack_empty),
        .full      (stack_full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        address = imm_sh;
        branch  = 1'b0;
        unique case (op)
            OP_BR:   branch = taken;
            OP_CALL: branch = 1'b1;
            OP_RET: begin
                if (stack_empty) begin
                    address = '0;
                end else begin
                    branch  = 1'b1;
                    address = ras_top;
                end
            end
            default: branch = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_branch_unit_rs.sv
// Scoreboard bench for branch_unit_rs against a queue-based stack model.
// Directed test-plan sequence followed by randomized traffic.
module tb_branch_unit_rs;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       equal, less, w_flag;
    logic [3:0] flag_in;
    logic       branch_instr, call_instr, ret_instr;
    logic [5:0] immediate;
    logic [8:0] pc_next;
    logic [8:0] address;
    logic       branch;
    logic [3:0] flag_q;
    logic       stack_empty, stack_full, overflow, underflow;

    branch_unit_rs #(
        .IMM_W(6), .SHIFT(3), .ADDR_W(9), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .equal(equal), .less(less),
        .w_flag(w_flag), .flag_in(flag_in),
        .branch_instr(branch_instr), .call_instr(call_instr),
        .ret_instr(ret_instr), .immediate(immediate),
        .pc_next(pc_next), .address(address), .branch(branch),
        .flag_q(flag_q), .stack_empty(stack_empty),
        .stack_full(stack_full), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       br;
        logic [8:0] addr;
        logic [3:0] flg;
        logic       emp, ful, ov, un;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit [3:0] m_flags = '0;
    bit [8:0] m_stk[$];
    bit       m_ov = 0, m_un = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("branch",      16'(branch),      16'(m_e.br));
            chk("address",     16'(address),     16'(m_e.addr));
            chk("flag_q",      16'(flag_q),      16'(m_e.flg));
            chk("stack_empty", 16'(stack_empty), 16'(m_e.emp));
            chk("stack_full",  16'(stack_full),  16'(m_e.ful));
            chk("overflow",    16'(overflow),    16'(m_e.ov));
            chk("underflow",   16'(underflow),   16'(m_e.un));
        end
    end

    task automatic step(input bit rst, input bit eq, input bit ls,
                        input bit wf, input bit [3:0] fin,
                        input bit br, input bit cl, input bit rt,
                        input bit [5:0] imm, input bit [8:0] pc);
        exp_t e;
        bit   tk;
        reset = rst; equal = eq; less = ls; w_flag = wf;
        flag_in = fin; branch_instr = br; call_instr = cl;
        ret_instr = rt; immediate = imm; pc_next = pc;

        tk = m_flags[0] || (m_flags[1] && ls) || (m_flags[2] && eq)
             || (m_flags[3] && !ls && !eq);
        e.addr = 9'(imm) * 9'd8;
        e.br   = 1'b0;
        if (rt) begin
            if (m_stk.size() > 0) begin
                e.br = 1'b1;
                e.addr = m_stk[m_stk.size()-1];
            end else begin
                e.addr = '0;
            end
        end else if (cl) begin
            e.br = 1'b1;
        end else if (br) begin
            e.br = tk;
        end
        e.flg = m_flags;
        e.emp = (m_stk.size() == 0);
        e.ful = (m_stk.size() == DEPTH);
        e.ov  = m_ov;
        e.un  = m_un;
        exp_q.push_back(e);

        if (rst) begin
            m_flags = '0; m_stk.delete(); m_ov = 0; m_un = 0;
        end else begin
            if (wf) m_flags = fin;
            if (rt) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_un = 1;
            end else if (cl) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ov = 1;
                end
                m_stk.push_back(pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; equal = 0; less = 0; w_flag = 0; flag_in = '0;
        branch_instr = 0; call_instr = 0; ret_instr = 0;
        immediate = '0; pc_next = '0;
        repeat (2) @(posedge clk);
        #1;

        // rst eq ls wf fin br cl rt imm pc
        step(0, 1, 1, 0, 4'b0000, 1, 0, 0, 6'd3, 9'd0);
        step(0, 1, 0, 1, 4'b0100, 1, 0, 0, 6'd5, 9'd0);
        step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 6'd5, 9'd0);
        step(0, 0, 0, 1, 4'b1000, 0, 0, 0, 6'd1, 9'd0);
        step(0, 0, 0, 0, 4'b0000, 1, 0, 0, 6'd7, 9'd0);
        step(0, 0, 1, 0, 4'b0000, 1, 0, 0, 6'd7, 9'd0);
        step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 6'd7, 9'd0);
        step(0, 0, 0, 1, 4'b0001, 0, 0, 0, 6'd0, 9'd0);
        for (int i = 0; i < 4; i++)
            step(0, i[0], i[1], 0, 4'b0000, 1, 0, 0, 6'd63, 9'd0);
        step(0, 0, 0, 1, 4'b0000, 0, 0, 0, 6'd0, 9'd0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 4'b0000, 0, 1, 0, 6'(i + 2), 9'(10 + i));
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 4'b0000, 0, 0, 1, 6'd9, 9'd0);
        step(0, 0, 0, 0, 4'b0000, 0, 0, 1, 6'd9, 9'd0);
        step(0, 0, 0, 0, 4'b0000, 1, 0, 0, 6'd2, 9'd0);
        step(0, 0, 0, 0, 4'b0000, 0, 1, 0, 6'd4, 9'd20);
        step(0, 0, 0, 0, 4'b0000, 1, 1, 1, 6'd4, 9'd99);
        step(0, 0, 0, 0, 4'b0000, 0, 0, 0, 6'd4, 9'd0);
        step(0, 0, 0, 1, 4'b0110, 0, 1, 0, 6'd1, 9'd30);
        step(0, 0, 0, 0, 4'b0000, 0, 1, 0, 6'd1, 9'd31);
        step(1, 0, 0, 0, 4'b0000, 0, 1, 0, 6'd1, 9'd32);
        step(0, 0, 0, 0, 4'b0000, 0, 0, 1, 6'd1, 9'd0);
        step(0, 0, 0, 0, 4'b0000, 0, 0, 0, 6'd1, 9'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom),
                 1'($urandom), ($urandom % 3) == 0,
                 ($urandom % 4) == 0,
                 6'($urandom), 9'($urandom));
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
